game_control_grid: RTL and testbench

//  Parametrised top-level game sequencer for the N x N sliding-tile (2048) board. Owns the game FSM.

---
 rtl/game_control_grid.sv | 225 ++++++++++++++++++++++
 tb/tb_game_control_grid.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_control_grid.sv
// game_control_grid
//   Top-level sequencer for an N x N sliding-tile (2048) board. Edge-detects
//   one-hot direction presses, runs req/ack handshakes with an external move
//   unit and spawn unit, skips the spawn when a move changes nothing, and
//   reports win/lose from the current board.
//
//   Ports
//     clock, reset        rising-edge clock, synchronous active-high reset
//     start               new-game request (level), honoured in IDLE/WAIT/END
//     direction[3:0]      one-hot key: 0001 left, 0010 right, 0100 down, 1000 up
//     board_in            current board, cell 0 (top-left) in the MSBs
//     mv_req/mv_dir       move request and direction (00 L, 01 R, 10 D, 11 U)
//     mv_ack/mv_board     move done, board after slide/merge
//     sp_req              spawn request
//     sp_ack/sp_board     spawn done, board with one new tile
//     board_out/update    board to load and its 1-cycle load strobe
//     endstatus[1:0]      00 playing, 01 win, 10 lose
//     state[2:0]          FSM state for debug
//
//   All outputs are registered: board_out/update show up the cycle after the
//   state that decided them, alongside the state that follows it.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   CLEAR | load an empty board, arm the initial spawns
//   SPAWN | request one tile from the spawn unit
//   WAIT  | game running, waiting for a key press
//   MOVE  | move request outstanding
//   CHECK | compare moved board with current board
//   END   | game over, waiting for start
module game_control_grid #(
  parameter int N       = 4,
  parameter int CELL_W  = 4,
  parameter int WIN_EXP = 11,
  parameter int INIT_N  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            direction,
  input  logic [N*N*CELL_W-1:0] board_in,
  output logic                  mv_req,
  output logic [1:0]            mv_dir,
  input  logic                  mv_ack,
  input  logic [N*N*CELL_W-1:0] mv_board,
  output logic                  sp_req,
  input  logic                  sp_ack,
  input  logic [N*N*CELL_W-1:0] sp_board,
  output logic [N*N*CELL_W-1:0] board_out,
  output logic                  update,
  output logic [1:0]            endstatus,
  output logic [2:0]            state
);

  localparam int CNT_W = $clog2(N*N+1);
  localparam logic [CELL_W-1:0] WIN_CODE = CELL_W'(WIN_EXP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SPAWN = 3'd2,
    S_WAIT  = 3'd3,
    S_MOVE  = 3'd4,
    S_CHECK = 3'd5,
    S_END   = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic                    mv_req_q, mv_req_d;
  logic [1:0]              mv_dir_q, mv_dir_d;
  logic                    sp_req_q, sp_req_d;
  logic [N*N*CELL_W-1:0]   board_out_q, board_out_d;
  logic                    update_q, update_d;
  logic [1:0]              endstatus_q, endstatus_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    init_q, init_d;
  logic [N*N*CELL_W-1:0]   moved_q, moved_d;
  logic [3:0]              dir_prev_q;

  logic [CELL_W-1:0] cells [N*N];
  logic              win, full, pair;
  logic              press;
  logic [1:0]        press_dir;

  // Board judgement. Horizontal neighbours must not wrap across row ends.
  always_comb begin
    win  = 1'b0;
    full = 1'b1;
    pair = 1'b0;
    for (int i = 0; i < N*N; i++) begin
      cells[i] = board_in[(N*N-1-i)*CELL_W +: CELL_W];
    end
    for (int i = 0; i < N*N; i++) begin
      if (cells[i] == WIN_CODE) win = 1'b1;
      if (cells[i] == '0) full = 1'b0;
    end
    for (int i = 0; i < N*N-1; i++) begin
      if ((i % N) != N-1 && cells[i] == cells[i+1]) pair = 1'b1;
    end
    for (int i = 0; i < N*N-N; i++) begin
      if (cells[i] == cells[i+N]) pair = 1'b1;
    end
    if (state_q == S_CLEAR) endstatus_d = 2'b00;
    else if (win)           endstatus_d = 2'b01;
    else if (full && !pair) endstatus_d = 2'b10;
    else                    endstatus_d = 2'b00;
  end

  // A press is a clean one-hot key arriving after an all-released cycle.
  always_comb begin
    press     = (dir_prev_q == 4'b0000);
    press_dir = 2'b00;
    unique case (direction)
      4'b0001: press_dir = 2'b00;
      4'b0010: press_dir = 2'b01;
      4'b0100: press_dir = 2'b10;
      4'b1000: press_dir = 2'b11;
      default: press     = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mv_req_d    = mv_req_q;
    mv_dir_d    = mv_dir_q;
    sp_req_d    = sp_req_q;
    board_out_d = board_out_q;
    update_d    = 1'b0;
    cnt_d       = cnt_q;
    init_d      = init_q;
    moved_d     = moved_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        board_out_d = '0;
        update_d    = 1'b1;
        cnt_d       = '0;
        init_d      = 1'b1;
        state_d     = S_SPAWN;
      end
      S_SPAWN: begin
        // Request drops for one cycle between back-to-back initial spawns.
        if (!sp_req_q) begin
          sp_req_d = 1'b1;
        end else if (sp_ack) begin
          board_out_d = sp_board;
          update_d    = 1'b1;
          sp_req_d    = 1'b0;
          if (init_q && (int'(cnt_q) + 1 < INIT_N)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            init_d  = 1'b0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (start)                    state_d = S_CLEAR;
        else if (endstatus_q != 2'b00) state_d = S_END;
        else if (press) begin
          mv_req_d = 1'b1;
          mv_dir_d = press_dir;
          state_d  = S_MOVE;
        end
      end
      S_MOVE: begin
        if (mv_req_q && mv_ack) begin
          moved_d  = mv_board;
          mv_req_d = 1'b0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (moved_q == board_in) begin
          state_d = S_WAIT;
        end else begin
          board_out_d = moved_q;
          update_d    = 1'b1;
          cnt_d       = '0;
          init_d      = 1'b0;
          state_d     = S_SPAWN;
        end
      end
      S_END: if (start) state_d = S_CLEAR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mv_req_q    <= 1'b0;
      mv_dir_q    <= 2'b00;
      sp_req_q    <= 1'b0;
      board_out_q <= '0;
      update_q    <= 1'b0;
      endstatus_q <= 2'b00;
      cnt_q       <= '0;
      init_q      <= 1'b0;
      moved_q     <= '0;
      dir_prev_q  <= 4'b0000;
    end else begin
      state_q     <= state_d;
      mv_req_q    <= mv_req_d;
      mv_dir_q    <= mv_dir_d;
      sp_req_q    <= sp_req_d;
      board_out_q <= board_out_d;
      update_q    <= update_d;
      endstatus_q <= endstatus_d;
      cnt_q       <= cnt_d;
      init_q      <= init_d;
      moved_q     <= moved_d;
      dir_prev_q  <= direction;
    end
  end

  assign mv_req    = mv_req_q;
  assign mv_dir    = mv_dir_q;
  assign sp_req    = sp_req_q;
  assign board_out = board_out_q;
  assign update    = update_q;
  assign endstatus = endstatus_q;
  assign state     = state_q;

endmodule

// File: tb/tb_game_control_grid.sv
module tb_game_control_grid;
  localparam int N = 4, CELL_W = 4, WIN_EXP = 11, INIT_N = 2;
  localparam int BW = N*N*CELL_W;
  localparam int P_IDLE = 0, P_CLEAR = 1, P_SPAWN = 2, P_WAIT = 3, P_MOVE = 4, P_CHECK = 5, P_END = 6;

  logic clock = 1'b0;
  logic reset, start, mv_ack, sp_ack;
  logic [3:0] direction;
  logic [BW-1:0] board_in, mv_board, sp_board, board_out;
  logic mv_req, sp_req, update;
  logic [1:0] mv_dir, endstatus;
  logic [2:0] state;

  int tests = 0, fails = 0;
  int upd_cnt = 0, sp_wait = 0;
  bit follow = 1'b0;

  always #5 clock = ~clock;

  game_control_grid #(.N(N), .CELL_W(CELL_W), .WIN_EXP(WIN_EXP), .INIT_N(INIT_N)) dut (
    .clock(clock), .reset(reset), .start(start), .direction(direction), .board_in(board_in),
    .mv_req(mv_req), .mv_dir(mv_dir), .mv_ack(mv_ack), .mv_board(mv_board),
    .sp_req(sp_req), .sp_ack(sp_ack), .sp_board(sp_board),
    .board_out(board_out), .update(update), .endstatus(endstatus), .state(state)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] judge(input logic [BW-1:0] b);
    int g [N][N];
    bit is_full, has_pair, has_win;
    is_full = 1'b1; has_pair = 1'b0; has_win = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        g[r][c] = int'(b[BW-1-(r*N+c)*CELL_W -: CELL_W]);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (g[r][c] == WIN_EXP) has_win = 1'b1;
        if (g[r][c] == 0) is_full = 1'b0;
        if (c + 1 < N) begin
          if (g[r][c] == g[r][c+1]) has_pair = 1'b1;
        end
        if (r + 1 < N) begin
          if (g[r][c] == g[r+1][c]) has_pair = 1'b1;
        end
      end
    end
    if (has_win) return 2'b01;
    if (is_full && !has_pair) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int dir_index(input logic [3:0] d);
    if ($countones(d) != 1) return -1;
    for (int i = 0; i < 4; i++) if (d[i]) return i;
    return -1;
  endfunction

  logic s_reset, s_start, s_mv_ack, s_sp_ack;
  logic [3:0] s_dir;
  logic [BW-1:0] s_board, s_mv_board, s_sp_board;
  always @(posedge clock) begin
    s_reset <= reset; s_start <= start; s_dir <= direction; s_board <= board_in;
    s_mv_ack <= mv_ack; s_mv_board <= mv_board; s_sp_ack <= sp_ack; s_sp_board <= sp_board;
  end

  int m_phase = P_IDLE, m_left = 0;
  logic [3:0] m_prev_dir = 4'b0;
  logic [BW-1:0] m_moved = '0, e_board = '0;
  logic e_mv_req = 1'b0, e_sp_req = 1'b0, e_update = 1'b0;
  logic [1:0] e_mv_dir = 2'b0, e_end = 2'b0;

  task automatic model_step();
    logic [1:0] nxt_end;
    e_update = 1'b0;
    if (s_reset) begin
      m_phase = P_IDLE; m_left = 0; m_prev_dir = 4'b0; m_moved = '0;
      e_mv_req = 1'b0; e_sp_req = 1'b0; e_mv_dir = 2'b0; e_board = '0; e_end = 2'b0;
      return;
    end
    nxt_end = (m_phase == P_CLEAR) ? 2'b00 : judge(s_board);
    case (m_phase)
      P_IDLE, P_END: if (s_start) m_phase = P_CLEAR;
      P_CLEAR: begin e_board = '0; e_update = 1'b1; m_left = INIT_N; m_phase = P_SPAWN; end
      P_SPAWN: begin
        if (!e_sp_req) e_sp_req = 1'b1;
        else if (s_sp_ack) begin
          e_board = s_sp_board; e_update = 1'b1; e_sp_req = 1'b0; m_left--;
          if (m_left == 0) m_phase = P_WAIT;
        end
      end
      P_WAIT: begin
        if (s_start) m_phase = P_CLEAR;
        else if (e_end != 2'b00) m_phase = P_END;
        else if (m_prev_dir == 4'b0 && dir_index(s_dir) >= 0) begin
          e_mv_req = 1'b1; e_mv_dir = 2'(dir_index(s_dir)); m_phase = P_MOVE;
        end
      end
      P_MOVE: if (s_mv_ack) begin m_moved = s_mv_board; e_mv_req = 1'b0; m_phase = P_CHECK; end
      P_CHECK: begin
        if (m_moved != s_board) begin
          e_board = m_moved; e_update = 1'b1; m_left = 1; m_phase = P_SPAWN;
        end else m_phase = P_WAIT;
      end
      default: m_phase = P_IDLE;
    endcase
    e_end = nxt_end;
    m_prev_dir = s_dir;
  endtask

  initial forever begin
    @(negedge clock);
    model_step();
    chk("cyc state", 64'(state), 64'(m_phase));
    chk("cyc mv_req", 64'(mv_req), 64'(e_mv_req));
    if (e_mv_req) chk("cyc mv_dir", 64'(mv_dir), 64'(e_mv_dir));
    chk("cyc sp_req", 64'(sp_req), 64'(e_sp_req));
    chk("cyc update", 64'(update), 64'(e_update));
    chk("cyc board_out", board_out, e_board);
    chk("cyc endstatus", 64'(endstatus), 64'(e_end));
  end

  // ---------------- environment ----------------
  function automatic logic [BW-1:0] spawn_into(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < N*N; i++) begin
      if (b[BW-1-i*CELL_W -: CELL_W] == '0) begin
        r[BW-1-i*CELL_W -: CELL_W] = CELL_W'(1);
        return r;
      end
    end
    return r;
  endfunction

  // One clock: board register follows update, spawn unit acks 2 cycles after sp_req.
  task automatic cyc();
    logic ld;
    logic [BW-1:0] lb;
    ld = update; lb = board_out;
    @(posedge clock); #1;
    if (follow && ld === 1'b1) board_in = lb;
    if (sp_ack) sp_ack = 1'b0;
    else if (sp_req === 1'b1) begin
      sp_wait++;
      if (sp_wait >= 2) begin sp_ack = 1'b1; sp_board = spawn_into(board_in); sp_wait = 0; end
    end else sp_wait = 0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
    int n;
    n = 0;
    while (state !== s && n < lim) begin
      cyc(); n++;
      if (update === 1'b1) upd_cnt++;
    end
    chk(nm, 64'(state), 64'(s));
  endtask

  task automatic wait_mv_req(input int lim, input string nm);
    int n;
    n = 0;
    while (mv_req !== 1'b1 && n < lim) begin cyc(); n++; end
    chk(nm, 64'(mv_req), 64'(1));
  endtask

  task automatic go_start();
    follow = 1'b1; start = 1'b1; cyc(); start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, rises2, spc;
    logic prev;
    logic [1:0] dir_seen;
    reset = 1'b1; start = 1'b0; direction = 4'b0; board_in = '0;
    mv_ack = 1'b0; mv_board = '0; sp_ack = 1'b0; sp_board = '0;
    repeat (3) cyc();
    reset = 1'b0;
    chk("reset state", 64'(state), 64'(0));
    chk("reset update", 64'(update), 64'(0));
    chk("reset board_out", board_out, 64'h0);
    chk("reset endstatus", 64'(endstatus), 64'(0));
    cyc();

    // 1) new game: CLEAR load + two spawns
    go_start();
    upd_cnt = 0;
    wait_state(3'd3, 40, "t1 reach WAIT");
    chk("t1 update count", 64'(upd_cnt), 64'(3));
    cyc();
    chk("t1 board", board_in, 64'h1100_0000_0000_0000);
    chk("t1 sp_req low", 64'(sp_req), 64'(0));

    // 2) held right key gives exactly one move
    direction = 4'b0010;
    rises = 0; prev = mv_req; dir_seen = 2'b00;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (mv_req && !prev) rises++;
      if (mv_req) dir_seen = mv_dir;
      prev = mv_req;
    end
    chk("t2 one mv_req", 64'(rises), 64'(1));
    chk("t2 mv_dir", 64'(dir_seen), 64'(2'b01));
    mv_board = 64'h0002_0000_0000_0000; mv_ack = 1'b1; cyc(); mv_ack = 1'b0;
    wait_state(3'd3, 40, "t2 back to WAIT");
    rises2 = 0; prev = mv_req;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (mv_req && !prev) rises2++;
      prev = mv_req;
    end
    chk("t2 held key no repeat", 64'(rises2), 64'(0));
    chk("t2 board", board_in, 64'h1002_0000_0000_0000);
    direction = 4'b0; cyc();

    // 3) no-op move: no update, no spawn
    direction = 4'b0001; cyc(); direction = 4'b0;
    wait_mv_req(10, "t3 mv_req");
    chk("t3 mv_dir", 64'(mv_dir), 64'(2'b00));
    mv_board = board_in; mv_ack = 1'b1; cyc(); mv_ack = 1'b0;
    upd_cnt = 0; spc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (update === 1'b1) upd_cnt++;
      if (sp_req === 1'b1) spc++;
    end
    chk("t3 no update", 64'(upd_cnt), 64'(0));
    chk("t3 no sp_req", 64'(spc), 64'(0));
    chk("t3 state WAIT", 64'(state), 64'(3));

    // 4) win board
    follow = 1'b0;
    board_in = 64'h1002_0B00_0000_0000;
    cyc();
    chk("t4 endstatus win", 64'(endstatus), 64'(2'b01));
    cyc();
    chk("t4 state END", 64'(state), 64'(6));
    direction = 4'b0100;
    repeat (4) cyc();
    chk("t4 dir ignored mv_req", 64'(mv_req), 64'(0));
    chk("t4 dir ignored state", 64'(state), 64'(6));
    direction = 4'b0;
    go_start();
    chk("t4 start to CLEAR", 64'(state), 64'(1));
    wait_state(3'd3, 40, "t4 new game WAIT");
    cyc();

    // 5) lose detection and its boundaries
    follow = 1'b0;
    board_in = 64'h1212_2121_1212_2121;
    cyc();
    chk("t5 checkerboard lose", 64'(endstatus), 64'(2'b10));
    cyc();
    chk("t5 state END", 64'(state), 64'(6));
    board_in = 64'h1112_2121_1212_2121; cyc();
    chk("t5 adjacent pair", 64'(endstatus), 64'(2'b00));
    board_in = 64'h1234_4678_1234_5678; cyc();
    chk("t5 row wrap not adjacent", 64'(endstatus), 64'(2'b10));
    board_in = 64'h1234_4678_1234_5608; cyc();
    chk("t5 one empty cell", 64'(endstatus), 64'(2'b00));
    board_in = 64'hB234_4678_1234_5678; cyc();
    chk("t5 win over lose", 64'(endstatus), 64'(2'b01));
    chk("t5 END holds", 64'(state), 64'(6));
    go_start();
    wait_state(3'd3, 40, "t5 new game WAIT");
    cyc();

    // 6) reset during MOVE, late acks ignored
    direction = 4'b1000; cyc(); direction = 4'b0;
    wait_mv_req(10, "t6 mv_req");
    chk("t6 mv_dir up", 64'(mv_dir), 64'(2'b11));
    cyc(); cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("t6 mv_req dropped", 64'(mv_req), 64'(0));
    chk("t6 state IDLE", 64'(state), 64'(0));
    mv_board = 64'hFFFF_0000_0000_0000; mv_ack = 1'b1; cyc(); mv_ack = 1'b0;
    sp_board = 64'h2222_0000_0000_0000; sp_ack = 1'b1;
    upd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (update === 1'b1) upd_cnt++;
    end
    chk("t6 late ack no update", 64'(upd_cnt), 64'(0));
    chk("t6 still IDLE", 64'(state), 64'(0));
    chk("t6 board_out clear", board_out, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
